// File: rtl/debug_instr_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : debug_instr_loader                                         |
// | Description : Packs UART bytes (LSB first) into instruction words, writes |
// |               them to instruction memory until the halt word, then       |
// |               captures the execution-mode command byte.                  |
// |               Optional macro LOADER_CHECKSUM_EN enables the byte XOR.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module debug_instr_loader #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DATA_WIDTH_UART = 8,
  parameter int                    ADDR_WIDTH      = 5,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD       = 32'hFC000000
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_rx_done,
  input  logic [DATA_WIDTH_UART-1:0] i_rx_data,
  input  logic                       i_reload,
  output logic                       o_imem_we,
  output logic [ADDR_WIDTH-1:0]      o_imem_addr,
  output logic [DATA_WIDTH-1:0]      o_imem_data,
  output logic                       o_load_done,
  output logic                       o_cmd_valid,
  output logic [DATA_WIDTH_UART-1:0] o_cmd,
  output logic                       o_overflow,
  output logic [ADDR_WIDTH:0]        o_word_count,
  output logic [DATA_WIDTH_UART-1:0] o_checksum
);

  localparam int                  c_LOW_W     = DATA_WIDTH - DATA_WIDTH_UART;
  localparam logic [1:0]          c_LAST_BYTE = 2'(DATA_WIDTH / DATA_WIDTH_UART - 1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_CMD   = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [1:0]                  r_byte_cnt;
  logic [c_LOW_W-1:0]          r_low;
  logic [ADDR_WIDTH-1:0]       r_word_ptr;
  logic [ADDR_WIDTH:0]         r_word_count;
  logic                        r_we;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [DATA_WIDTH-1:0]       r_data;
  logic                        r_load_done;
  logic                        r_cmd_valid;
  logic [DATA_WIDTH_UART-1:0]  r_cmd;
  logic                        r_overflow;

  logic                        w_accept;
  logic                        w_load_accept;
  logic                        w_last_byte;
  logic [DATA_WIDTH-1:0]       w_full_word;
  logic                        w_is_halt;
  logic                        w_ptr_end;

  // Reload outranks a coincident byte strobe, so the byte is simply dropped.
  assign w_accept      = i_rx_done && !i_reload;
  assign w_load_accept = w_accept && (r_state == S_LOAD);
  assign w_last_byte   = w_load_accept && (r_byte_cnt == c_LAST_BYTE);
  assign w_full_word   = {i_rx_data, r_low};
  assign w_is_halt     = (w_full_word == HALT_WORD);
  assign w_ptr_end     = (r_word_ptr == c_PTR_MAX);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_reload) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (w_last_byte && (w_is_halt || w_ptr_end)) w_state_nxt = S_CMD;
        S_CMD:   if (w_accept) w_state_nxt = S_READY;
        S_READY: w_state_nxt = S_READY;
        default: w_state_nxt = S_LOAD;
      endcase
    end
  end

  // Bytes shift in from the top, so after three bytes the lowest arrived byte
  // sits in bits [7:0] and the fourth byte completes the word combinationally.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_byte_cnt   <= '0;
      r_low        <= '0;
      r_word_ptr   <= '0;
      r_word_count <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_load_done  <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd        <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_we        <= 1'b0;
      r_cmd_valid <= 1'b0;
      if (i_reload) begin
        r_byte_cnt   <= '0;
        r_low        <= '0;
        r_word_ptr   <= '0;
        r_word_count <= '0;
        r_load_done  <= 1'b0;
        r_overflow   <= 1'b0;
      end else if (w_load_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_low      <= {i_rx_data, r_low[c_LOW_W-1:DATA_WIDTH_UART]};
        if (w_last_byte) begin
          r_we         <= 1'b1;
          r_addr       <= r_word_ptr;
          r_data       <= w_full_word;
          r_word_count <= r_word_count + c_CNT_ONE;
          // The pointer saturates on the last word instead of wrapping.
          if (!w_ptr_end) begin
            r_word_ptr <= r_word_ptr + c_PTR_ONE;
          end
          if (w_ptr_end && !w_is_halt) begin
            r_overflow <= 1'b1;
          end
        end
      end else if (w_accept && (r_state == S_CMD)) begin
        r_cmd       <= i_rx_data;
        r_cmd_valid <= 1'b1;
        r_load_done <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH_UART-1:0] r_checksum;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_checksum <= '0;
    end else if (i_reload) begin
      r_checksum <= '0;
    end else if (w_load_accept) begin
      r_checksum <= r_checksum ^ i_rx_data;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_data  = r_data;
  assign o_load_done  = r_load_done;
  assign o_cmd_valid  = r_cmd_valid;
  assign o_cmd        = r_cmd;
  assign o_overflow   = r_overflow;
  assign o_word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_debug_instr_loader.sv
`default_nettype none
// Scoreboard bench for debug_instr_loader: a per-byte behavioural model queues
// expected writes/commands; a negedge monitor pops and compares them.
module tb_debug_instr_loader;

  localparam logic [31:0] HALT = 32'hFC000000;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_rx_done = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_reload = 1'b0;
  logic        o_imem_we;
  logic [4:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic        o_load_done;
  logic        o_cmd_valid;
  logic [7:0]  o_cmd;
  logic        o_overflow;
  logic [5:0]  o_word_count;
  logic [7:0]  o_checksum;

  debug_instr_loader dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx_done(i_rx_done),
    .i_rx_data(i_rx_data), .i_reload(i_reload), .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_load_done(o_load_done), .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd),
    .o_overflow(o_overflow), .o_word_count(o_word_count), .o_checksum(o_checksum)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [7:0] cmd; int cyc; } cmd_t;
  wr_t  exp_wr[$];
  cmd_t exp_cmd[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a program is a list of words; loading stops after the
  // halt word or after the 32nd word, then one byte is the command.
  int         m_mode;        // 0 loading, 1 awaiting command, 2 ready
  logic [7:0] m_bytes[$];
  int         m_nwords;
  logic       m_overflow;
  logic [7:0] m_csum;
  logic [7:0] m_cmd;
  logic       m_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_restart(input bit clear_cmd);
    m_mode = 0; m_bytes.delete(); m_nwords = 0; m_overflow = 1'b0;
    m_csum = 8'h00; m_done = 1'b0;
    if (clear_cmd) m_cmd = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    wr_t e;
    cmd_t c;
    if (m_mode == 0) begin
      m_bytes.push_back(b);
      m_csum ^= b;
      if (m_bytes.size() == 4) begin
        w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        m_bytes.delete();
        e.addr = 5'(m_nwords < 32 ? m_nwords : 31);
        e.data = w; e.cyc = cyc + 1;
        exp_wr.push_back(e);
        m_nwords++;
        if (w == HALT) m_mode = 1;
        else if (m_nwords == 32) begin m_mode = 1; m_overflow = 1'b1; end
      end
    end else if (m_mode == 1) begin
      c.cmd = b; c.cyc = cyc + 1;
      exp_cmd.push_back(c);
      m_cmd = b; m_done = 1'b1; m_mode = 2;
    end
  endtask

  always @(negedge i_clock) begin
    wr_t e; cmd_t c;
    if (o_imem_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: actual addr=%0h data=%0h required none", o_imem_addr, o_imem_data);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", 64'(o_imem_addr), 64'(e.addr));
        chk("wr_data", 64'(o_imem_data), 64'(e.data));
        chk("wr_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (o_cmd_valid) begin
      if (exp_cmd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_cmd: actual cmd=%0h required none", o_cmd);
      end else begin
        c = exp_cmd.pop_front();
        chk("cmd_value", 64'(o_cmd), 64'(c.cmd));
        chk("cmd_cycle", 64'(cyc), 64'(c.cyc));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clock); #1;
      i_rx_done = 1'b0; i_reload = 1'b0; i_reset = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clock); #1;
    i_rx_done = 1'b1; i_rx_data = b;
    model_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 2));
    end
  endtask

  task automatic do_reset();
    @(posedge i_clock); #1;
    i_rx_done = 1'b0; i_reload = 1'b0; i_reset = 1'b0;
    model_restart(1'b1);
    idle(1);
  endtask

  task automatic do_reload(input bit with_byte, input logic [7:0] b);
    @(posedge i_clock); #1;
    i_reload = 1'b1; i_rx_done = with_byte; i_rx_data = b;
    model_restart(1'b0);
    idle(1);
  endtask

  task automatic check_status(input string tag);
    logic [7:0] exp_cs;
`ifdef LOADER_CHECKSUM_EN
    exp_cs = m_csum;
`else
    exp_cs = 8'h00;
`endif
    idle(2);
    @(negedge i_clock);
    chk({tag, "_word_count"}, 64'(o_word_count), 64'(m_nwords));
    chk({tag, "_overflow"},   64'(o_overflow),   64'(m_overflow));
    chk({tag, "_load_done"},  64'(o_load_done),  64'(m_done));
    chk({tag, "_cmd"},        64'(o_cmd),        64'(m_cmd));
    chk({tag, "_checksum"},   64'(o_checksum),   64'(exp_cs));
  endtask

  initial begin
    logic [7:0]  exp_plan;
    logic [31:0] w;
    model_restart(1'b1);
    idle(0);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b1;
    @(negedge i_clock);
    chk("reset_we", 64'(o_imem_we), 64'd0);
    chk("reset_cmd_valid", 64'(o_cmd_valid), 64'd0);
    chk("reset_addr", 64'(o_imem_addr), 64'd0);
    chk("reset_data", 64'(o_imem_data), 64'd0);
    check_status("reset");

    // First word, gapped strobes
    send_word(32'hAC410008, 1'b1);
    check_status("first_word");

    // Continue to a halt word then a continuous-mode command
    send_word(32'hA0220008, 1'b0);
    send_word(HALT, 1'b0);
    send_byte(8'h00);
    check_status("halt_cmd");

    // Fill memory without halt, back-to-back strobes, then step command
    do_reset();
    for (int i = 0; i < 32; i++) send_word(32'h00000000, 1'b0);
    send_byte(8'h01);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    check_status("overflow");

    // Reset in the middle of a word discards it
    send_byte(8'h11); send_byte(8'h22);
    do_reset();
    send_word(32'h20430005, 1'b1);
    check_status("reset_midword");

    // Reload from ready with a coincident byte
    send_word(HALT, 1'b0);
    send_byte(8'h01);
    check_status("pre_reload");
    do_reload(1'b1, 8'h5A);
    check_status("reload");
    send_word(32'h12345678, 1'b0);
    check_status("after_reload");

    // Checksum of the documented two-word program
    do_reset();
    send_word(32'hAC410008, 1'b0);
    send_word(HALT, 1'b0);
    idle(3);
`ifdef LOADER_CHECKSUM_EN
    exp_plan = 8'h19;
`else
    exp_plan = 8'h00;
`endif
    @(negedge i_clock);
    chk("checksum_plan", 64'(o_checksum), 64'(exp_plan));

    // Randomized programs with occasional reloads and halt words
    for (int it = 0; it < 12; it++) begin
      do_reset();
      for (int n = $urandom_range(1, 40); n > 0; n--) begin
        w = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
        if ($urandom_range(0, 19) == 0) begin
          send_byte(8'($urandom));
          do_reload($urandom_range(0, 1) == 1, 8'($urandom));
        end
        send_word(w, 1'b1);
      end
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      check_status("random");
    end

    idle(4);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_instr_loader.md
Name: debug_instr_loader

Overview:
- Debug-unit stage directly downstream of the UART receiver, upstream of the instruction memory of TOP_MIPS.
- Assembles received bytes, least-significant byte first, into 32-bit instructions and writes them sequentially into instruction memory.
- Loading ends on the halt word (opcode 111111, all other bits 0). The next byte is then captured as the execution-mode command for the debug controller.

Parameters:
DATA_WIDTH, 32, instruction word width
DATA_WIDTH_UART, 8, UART byte width
ADDR_WIDTH, 5, instruction memory word-address width (32 words)
HALT_WORD, 32'hFC000000, word that terminates loading

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous reset, active-low
i_rx_done  in  1  one-cycle strobe, UART byte valid
i_rx_data  in  DATA_WIDTH_UART  received byte
i_reload  in  1  one-cycle pulse, restart loading at address 0
o_imem_we  out  1  instruction memory write enable, one-cycle pulse
o_imem_addr  out  ADDR_WIDTH  write word address
o_imem_data  out  DATA_WIDTH  write data
o_load_done  out  1  level, program loaded and command received
o_cmd_valid  out  1  one-cycle pulse, command byte valid
o_cmd  out  DATA_WIDTH_UART  command byte (0x00 continuous, 0x01 step; others passed through)
o_overflow  out  1  sticky, memory filled without halt word
o_word_count  out  ADDR_WIDTH+1  words written since last reset/reload
o_checksum  out  DATA_WIDTH_UART  running XOR of program bytes (see Optional Feature)

Behaviour:
- Reset (i_reset==0 at clock edge):
  - state=S_LOAD; byte_cnt=0; word register=0; word_ptr=0.
  - All outputs 0.
  - Reset mid-word discards the partial word.
- S_LOAD, on i_rx_done:
  - Place the byte at word[8*byte_cnt +: 8]; byte_cnt increments, wrapping 3->0.
  - On the 4th byte (byte_cnt==3), next cycle: o_imem_we=1, o_imem_addr=word_ptr, o_imem_data=assembled word.
  - Latency: 1 cycle from the 4th-byte strobe to the write pulse.
  - Same cycle as the write pulse: word_ptr++ and o_word_count++.
- S_LOAD, halt detection:
  - If the assembled word == HALT_WORD, it is still written, then state -> S_CMD.
- S_LOAD, overflow:
  - If word_ptr == 2^ADDR_WIDTH-1 and the word is not HALT_WORD, the write occurs, o_overflow=1 (sticky), state -> S_CMD.
  - word_ptr never wraps.
- S_CMD, on i_rx_done:
  - Next cycle: o_cmd=byte, o_cmd_valid=1 for one cycle, o_load_done=1.
  - State -> S_READY.
- S_READY:
  - i_rx_done ignored; o_cmd holds; o_load_done holds 1.
- i_reload (any state):
  - Next cycle: state=S_LOAD, byte_cnt=0, word_ptr=0, o_word_count=0, o_load_done=0, o_overflow=0, o_checksum=0.
  - o_cmd holds.
  - Reload discards any partial word.
- Simultaneous i_reload and i_rx_done: reload wins, byte dropped.
- i_rx_done asserted on consecutive cycles: each strobe is a distinct byte; no minimum spacing is required.
- o_imem_we is never asserted outside S_LOAD, and never twice for one word.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: o_checksum XOR-accumulates every byte accepted in S_LOAD, halt-word bytes included, command byte excluded.
- Undefined: o_checksum tied to 0 and the accumulator is not instantiated.

Test Plan:
- Reset, then bytes 08,00,41,AC -> one o_imem_we pulse 1 cycle after the 4th strobe, addr 0, data 32'hAC410008; o_word_count=1.
- Words AC410008, A0220008, FC000000, then byte 00 -> writes at addr 0,1,2; o_cmd_valid pulse with o_cmd=8'h00; o_load_done=1; o_word_count=3.
- 32 words of 32'h00000000, no halt -> 32 writes (addr 0..31), o_overflow=1, next byte 01 -> o_cmd=8'h01; further bytes produce no writes.
- Two bytes sent, i_reset=0 for one cycle, then bytes 05,00,43,20 -> single write addr 0, data 32'h20430005.
- In S_READY, i_reload pulsed in the same cycle as i_rx_done -> byte dropped, o_load_done=0; next full word written at addr 0.
- With LOADER_CHECKSUM_EN: words 32'hAC410008 and HALT_WORD -> o_checksum=8'h08^8'h41^8'hAC^8'hFC=8'h19. Without the macro -> o_checksum=0.
